// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction-fetch stage with PC register, single outstanding bus request,
// delay-slot redirects and flushes. Optional macro FETCH_ADEL_CHECK_EN enables fetch address-error checking.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        ifj,
  input  logic [31:0] pc_decode,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        d_valid,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic        d_adel,
  output logic [1:0]  dbg_state,
  output logic        dbg_redir_pending,
  output logic        dbg_kill
);

  // Handshakes: a request transfers on a cycle with ireq_valid & ireq_ready, and ireq_addr holds
  // until then except on flush; a response transfers on any cycle with iresp_valid while in S_WAIT.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] redir_pc_q;
  logic        redir_pending_q;
  logic        kill_q, kill_d;
  logic [31:0] hold_q;
  logic        adel_req;
  logic        adel_deliver;
  logic        deliver;
  logic        redirect;
  logic        flush_to_wait;
  logic [31:0] deliver_word;
  logic [31:0] next_pc;

`ifdef FETCH_ADEL_CHECK_EN
  logic adel_done_q;

  assign adel_req     = (pc_q[1:0] != 2'b00);
  assign ireq_addr    = pc_q;
  assign adel_deliver = (state_q == S_REQ) && adel_req && !adel_done_q && !stall && !flush;

  // Once the error has been handed to decode, fetch parks until a flush supplies a new PC.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)           adel_done_q <= 1'b0;
    else if (flush)        adel_done_q <= 1'b0;
    else if (adel_deliver) adel_done_q <= 1'b1;
  end
`else
  assign adel_req     = 1'b0;
  assign ireq_addr    = {pc_q[31:2], 2'b00};
  assign adel_deliver = 1'b0;
`endif

  assign ireq_valid = (state_q == S_REQ) && !adel_req;

  // An instruction completes when it enters the decode register.
  assign deliver = !flush && !stall &&
                   (((state_q == S_WAIT) && iresp_valid && !kill_q) || (state_q == S_HOLD));
  assign deliver_word = (state_q == S_HOLD) ? hold_q : iresp_data;
  assign redirect     = ifj && !stall && !flush;
  assign next_pc      = redirect        ? pc_decode  :
                        redir_pending_q ? redir_pc_q : pc_q + 32'd4;

  // A request already accepted (or accepted in this very cycle) must have its response discarded.
  assign flush_to_wait = ((state_q == S_REQ) && ireq_valid && ireq_ready) ||
                         ((state_q == S_WAIT) && !iresp_valid);

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    case (state_q)
      S_REQ:  if (ireq_valid && ireq_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (iresp_valid) begin
          kill_d = 1'b0;
          if (kill_q)     state_d = S_REQ;
          else if (stall) state_d = S_HOLD;
          else            state_d = S_REQ;
        end
      end
      S_HOLD: if (!stall) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
    if (flush) begin
      state_d = flush_to_wait ? S_WAIT : S_REQ;
      kill_d  = flush_to_wait;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= S_REQ;
      kill_q          <= 1'b0;
      pc_q            <= RESET_PC;
      redir_pending_q <= 1'b0;
      redir_pc_q      <= 32'd0;
      hold_q          <= 32'd0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      if (flush)        pc_q <= flush_pc;
      else if (deliver) pc_q <= next_pc;
      if (flush || deliver) begin
        redir_pending_q <= 1'b0;
      end else if (redirect) begin
        redir_pending_q <= 1'b1;
        redir_pc_q      <= pc_decode;
      end
      if (!flush && (state_q == S_WAIT) && iresp_valid && !kill_q && stall)
        hold_q <= iresp_data;
    end
  end

  // Decode register: loads only when decode accepts; otherwise holds. Empty slots carry zeros.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d_valid <= 1'b0;
      d_pc    <= 32'd0;
      d_instr <= 32'd0;
      d_adel  <= 1'b0;
    end else if (flush) begin
      d_valid <= 1'b0;
      d_instr <= 32'd0;
      d_adel  <= 1'b0;
    end else if (!stall) begin
      if (deliver) begin
        d_valid <= 1'b1;
        d_pc    <= pc_q;
        d_instr <= deliver_word;
        d_adel  <= 1'b0;
      end else if (adel_deliver) begin
        d_valid <= 1'b1;
        d_pc    <= pc_q;
        d_instr <= 32'd0;
        d_adel  <= 1'b1;
      end else begin
        d_valid <= 1'b0;
        d_instr <= 32'd0;
        d_adel  <= 1'b0;
      end
    end
  end

  assign dbg_state         = state_q;
  assign dbg_redir_pending = redir_pending_q;
  assign dbg_kill          = kill_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized run checked against a program-order fetch model.
// Built with or without FETCH_ADEL_CHECK_EN.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk;
  logic        resetn;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        stall;
  logic        ifj;
  logic [31:0] pc_decode;
  logic        flush;
  logic [31:0] flush_pc;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic        d_adel;
  logic [1:0]  dbg_state;
  logic        dbg_redir_pending;
  logic        dbg_kill;

  int total;
  int bad;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .resetn(resetn),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
    .iresp_valid(iresp_valid), .iresp_data(iresp_data),
    .stall(stall), .ifj(ifj), .pc_decode(pc_decode),
    .flush(flush), .flush_pc(flush_pc),
    .d_valid(d_valid), .d_pc(d_pc), .d_instr(d_instr), .d_adel(d_adel),
    .dbg_state(dbg_state), .dbg_redir_pending(dbg_redir_pending), .dbg_kill(dbg_kill)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h2408_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ireq_ready = 1'b0; iresp_valid = 1'b0; iresp_data = 32'd0;
    stall = 1'b0; ifj = 1'b0; pc_decode = 32'd0; flush = 1'b0; flush_pc = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    #1;
  endtask

  task automatic fetch_one(input logic [31:0] word);
    ireq_ready = 1'b1;
    tick();
    ireq_ready  = 1'b0;
    iresp_valid = 1'b1;
    iresp_data  = word;
    tick();
    iresp_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    #2;
    total++; if (d_valid !== 1'b0 || d_pc !== 32'd0 || d_instr !== 32'd0 || d_adel !== 1'b0) begin
      bad++; $display("FAIL reset_d: got v=%b pc=%h i=%h adel=%b want all zero", d_valid, d_pc, d_instr, d_adel); end
    tick();
    resetn = 1'b1;
    #1;
    total++; if (ireq_valid !== 1'b1 || ireq_addr !== RESET_PC) begin
      bad++; $display("FAIL reset_req: got v=%b addr=%h want 1 %h", ireq_valid, ireq_addr, RESET_PC); end
    total++; if (dbg_redir_pending !== 1'b0 || dbg_kill !== 1'b0 || dbg_state !== 2'd0) begin
      bad++; $display("FAIL reset_state: got redir=%b kill=%b st=%0d want 0 0 0", dbg_redir_pending, dbg_kill, dbg_state); end
  endtask

  task automatic test_basic_fetch();
    fetch_one(32'h2408_0001);
    total++; if (d_valid !== 1'b1 || d_pc !== 32'hBFC0_0000 || d_instr !== 32'h2408_0001) begin
      bad++; $display("FAIL basic_d: got v=%b pc=%h i=%h want 1 bfc00000 24080001", d_valid, d_pc, d_instr); end
    total++; if (ireq_valid !== 1'b1 || ireq_addr !== 32'hBFC0_0004) begin
      bad++; $display("FAIL basic_next: got v=%b addr=%h want 1 bfc00004", ireq_valid, ireq_addr); end
  endtask

  task automatic test_stall_hold();
    stall = 1'b1;
    ireq_ready = 1'b1;
    tick();
    ireq_ready  = 1'b0;
    iresp_valid = 1'b1;
    iresp_data  = 32'h8C09_0004;
    for (int i = 0; i < 3; i++) begin
      tick();
      iresp_valid = 1'b0;
      total++; if (d_valid !== 1'b1 || d_pc !== 32'hBFC0_0000 || d_instr !== 32'h2408_0001) begin
        bad++; $display("FAIL stall_d%0d: got v=%b pc=%h i=%h want 1 bfc00000 24080001", i, d_valid, d_pc, d_instr); end
      total++; if (ireq_valid !== 1'b0 || dbg_state !== 2'd2) begin
        bad++; $display("FAIL stall_hold%0d: got req=%b st=%0d want 0 2", i, ireq_valid, dbg_state); end
    end
    stall = 1'b0;
    tick();
    total++; if (d_valid !== 1'b1 || d_pc !== 32'hBFC0_0004 || d_instr !== 32'h8C09_0004) begin
      bad++; $display("FAIL stall_release: got v=%b pc=%h i=%h want 1 bfc00004 8c090004", d_valid, d_pc, d_instr); end
    total++; if (ireq_valid !== 1'b1 || ireq_addr !== 32'hBFC0_0008) begin
      bad++; $display("FAIL stall_next: got v=%b addr=%h want 1 bfc00008", ireq_valid, ireq_addr); end
  endtask

  task automatic test_branch();
    fetch_one(32'h0000_0008);
    fetch_one(32'h0000_000C);
    fetch_one(32'h1000_003B);
    total++; if (d_pc !== 32'hBFC0_0010 || d_instr !== 32'h1000_003B) begin
      bad++; $display("FAIL br_branch: got pc=%h i=%h want bfc00010 1000003b", d_pc, d_instr); end
    ifj = 1'b1; pc_decode = 32'hBFC0_0100; ireq_ready = 1'b1;
    tick();
    ifj = 1'b0; ireq_ready = 1'b0;
    total++; if (dbg_redir_pending !== 1'b1) begin
      bad++; $display("FAIL br_pending: got %b want 1", dbg_redir_pending); end
    iresp_valid = 1'b1; iresp_data = 32'h2409_0002;
    tick();
    iresp_valid = 1'b0;
    total++; if (d_valid !== 1'b1 || d_pc !== 32'hBFC0_0014 || d_instr !== 32'h2409_0002) begin
      bad++; $display("FAIL br_slot: got v=%b pc=%h i=%h want 1 bfc00014 24090002", d_valid, d_pc, d_instr); end
    total++; if (ireq_addr !== 32'hBFC0_0100 || dbg_redir_pending !== 1'b0) begin
      bad++; $display("FAIL br_target: got addr=%h redir=%b want bfc00100 0", ireq_addr, dbg_redir_pending); end
    ireq_ready = 1'b1;
    tick();
    ireq_ready = 1'b0;
    iresp_valid = 1'b1; iresp_data = 32'h3C0A_0001; ifj = 1'b1; pc_decode = 32'hBFC0_0200;
    tick();
    iresp_valid = 1'b0; ifj = 1'b0;
    total++; if (d_valid !== 1'b1 || d_pc !== 32'hBFC0_0100 || d_instr !== 32'h3C0A_0001) begin
      bad++; $display("FAIL bypass_slot: got v=%b pc=%h i=%h want 1 bfc00100 3c0a0001", d_valid, d_pc, d_instr); end
    total++; if (ireq_addr !== 32'hBFC0_0200 || dbg_redir_pending !== 1'b0) begin
      bad++; $display("FAIL bypass_target: got addr=%h redir=%b want bfc00200 0", ireq_addr, dbg_redir_pending); end
  endtask

  task automatic test_flush_wait();
    ireq_ready = 1'b1;
    tick();
    ireq_ready = 1'b0;
    flush = 1'b1; flush_pc = 32'hBFC0_0380;
    tick();
    flush = 1'b0;
    total++; if (d_valid !== 1'b0 || dbg_kill !== 1'b1 || ireq_valid !== 1'b0) begin
      bad++; $display("FAIL flush_kill: got v=%b kill=%b req=%b want 0 1 0", d_valid, dbg_kill, ireq_valid); end
    iresp_valid = 1'b1; iresp_data = 32'hDEAD_BEEF;
    tick();
    iresp_valid = 1'b0;
    total++; if (d_valid !== 1'b0 || d_instr !== 32'd0) begin
      bad++; $display("FAIL flush_discard: got v=%b i=%h want 0 0", d_valid, d_instr); end
    total++; if (ireq_valid !== 1'b1 || ireq_addr !== 32'hBFC0_0380 || dbg_kill !== 1'b0) begin
      bad++; $display("FAIL flush_req: got v=%b addr=%h kill=%b want 1 bfc00380 0", ireq_valid, ireq_addr, dbg_kill); end
    fetch_one(32'h4200_0018);
    total++; if (d_valid !== 1'b1 || d_pc !== 32'hBFC0_0380 || d_instr !== 32'h4200_0018) begin
      bad++; $display("FAIL flush_first: got v=%b pc=%h i=%h want 1 bfc00380 42000018", d_valid, d_pc, d_instr); end
  endtask

  task automatic test_flush_ifj();
    ireq_ready = 1'b1;
    tick();
    ireq_ready = 1'b0;
    flush = 1'b1; flush_pc = 32'hBFC0_0400; ifj = 1'b1; pc_decode = 32'hBFC0_0500;
    tick();
    flush = 1'b0; ifj = 1'b0;
    total++; if (dbg_redir_pending !== 1'b0 || d_valid !== 1'b0) begin
      bad++; $display("FAIL fj_redir: got redir=%b v=%b want 0 0", dbg_redir_pending, d_valid); end
    iresp_valid = 1'b1; iresp_data = 32'h1111_1111;
    tick();
    iresp_valid = 1'b0;
    fetch_one(32'h2222_2222);
    total++; if (d_pc !== 32'hBFC0_0400 || ireq_addr !== 32'hBFC0_0404) begin
      bad++; $display("FAIL fj_target: got dpc=%h addr=%h want bfc00400 bfc00404", d_pc, ireq_addr); end
  endtask

  task automatic test_adel();
    flush = 1'b1; flush_pc = 32'hBFC0_0002;
    tick();
    flush = 1'b0;
`ifdef FETCH_ADEL_CHECK_EN
    total++; if (ireq_valid !== 1'b0) begin
      bad++; $display("FAIL adel_noreq: got %b want 0", ireq_valid); end
    tick();
    total++; if (d_valid !== 1'b1 || d_adel !== 1'b1 || d_pc !== 32'hBFC0_0002 || d_instr !== 32'd0) begin
      bad++; $display("FAIL adel_d: got v=%b adel=%b pc=%h i=%h want 1 1 bfc00002 0", d_valid, d_adel, d_pc, d_instr); end
    tick();
    total++; if (ireq_valid !== 1'b0 || d_valid !== 1'b0) begin
      bad++; $display("FAIL adel_park: got req=%b v=%b want 0 0", ireq_valid, d_valid); end
`else
    total++; if (ireq_valid !== 1'b1 || ireq_addr !== 32'hBFC0_0000 || d_adel !== 1'b0) begin
      bad++; $display("FAIL adel_off: got v=%b addr=%h adel=%b want 1 bfc00000 0", ireq_valid, ireq_addr, d_adel); end
`endif
    flush = 1'b1; flush_pc = 32'hBFC0_1000;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    ireq_ready = 1'b1;
    tick();
    ireq_ready = 1'b0;
    resetn = 1'b0;
    #1;
    total++; if (dbg_state !== 2'd0 || dbg_kill !== 1'b0 || d_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid: got st=%0d kill=%b v=%b want 0 0 0", dbg_state, dbg_kill, d_valid); end
    tick();
    resetn = 1'b1;
    #1;
    total++; if (ireq_valid !== 1'b1 || ireq_addr !== RESET_PC) begin
      bad++; $display("FAIL rst_mid_req: got v=%b addr=%h want 1 %h", ireq_valid, ireq_addr, RESET_PC); end
  endtask

  // Random run: the model tracks the next PC in program order and a pending branch target;
  // the bus side answers each accepted request with mem_word after 1..3 cycles.
  task automatic test_random(input int cycles);
    logic [31:0] exp_pc, tgt, out_addr;
    logic [31:0] pre_pc, pre_instr;
    logic        tgt_v, out_v, pre_valid, pre_adel;
    int          out_wait, deliveries;
    do_reset();
    exp_pc = RESET_PC; tgt = 32'd0; tgt_v = 1'b0; out_v = 1'b0; out_addr = 32'd0;
    out_wait = 0; deliveries = 0;
    for (int c = 0; c < cycles; c++) begin
      ireq_ready  = ($urandom_range(0, 3) != 0);
      stall       = ($urandom_range(0, 9) < 3);
      ifj         = ($urandom_range(0, 9) == 0);
      pc_decode   = RESET_PC + 32'($urandom_range(0, 1023)) * 32'd4;
      flush       = ($urandom_range(0, 29) == 0);
      flush_pc    = RESET_PC + 32'($urandom_range(0, 1023)) * 32'd4;
      iresp_valid = 1'b0;
      iresp_data  = $urandom;
      if (out_v) begin
        if (out_wait == 0) begin
          iresp_valid = 1'b1; iresp_data = mem_word(out_addr); out_v = 1'b0;
        end else begin
          out_wait--;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        iresp_valid = 1'b1;
      end
      #1;
      pre_valid = d_valid; pre_pc = d_pc; pre_instr = d_instr; pre_adel = d_adel;
      if (ireq_valid && ireq_ready) begin
        total++; if (ireq_addr !== exp_pc) begin
          bad++; $display("FAIL rnd_addr c%0d: got %h want %h", c, ireq_addr, exp_pc); end
        out_v = 1'b1; out_addr = ireq_addr; out_wait = $urandom_range(0, 2);
      end
      tick();
      if (flush) begin
        total++; if (d_valid !== 1'b0) begin
          bad++; $display("FAIL rnd_flush c%0d: got v=%b want 0", c, d_valid); end
        exp_pc = flush_pc; tgt_v = 1'b0;
      end else if (stall) begin
        total++; if (d_valid !== pre_valid || d_pc !== pre_pc || d_instr !== pre_instr || d_adel !== pre_adel) begin
          bad++; $display("FAIL rnd_stall c%0d: got v=%b pc=%h i=%h want v=%b pc=%h i=%h", c, d_valid, d_pc, d_instr, pre_valid, pre_pc, pre_instr); end
      end else begin
        if (ifj) begin tgt = pc_decode; tgt_v = 1'b1; end
        if (d_valid) begin
          deliveries++;
          total++; if (d_pc !== exp_pc || d_instr !== mem_word(exp_pc) || d_adel !== 1'b0) begin
            bad++; $display("FAIL rnd_deliver c%0d: got pc=%h i=%h want pc=%h i=%h", c, d_pc, d_instr, exp_pc, mem_word(exp_pc)); end
          exp_pc = tgt_v ? tgt : exp_pc + 32'd4;
          tgt_v = 1'b0;
        end
      end
      if (!d_valid) begin
        total++; if (d_instr !== 32'd0 || d_adel !== 1'b0) begin
          bad++; $display("FAIL rnd_bubble c%0d: got i=%h adel=%b want 0 0", c, d_instr, d_adel); end
      end
    end
    idle_inputs();
    total++; if (deliveries < cycles / 20) begin
      bad++; $display("FAIL rnd_progress: got %0d deliveries want at least %0d", deliveries, cycles / 20); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    resetn = 1'b0;
    idle_inputs();
    tick();
    test_reset();
    test_basic_fetch();
    test_stall_hold();
    test_branch();
    test_flush_wait();
    test_flush_ifj();
    test_adel();
    test_reset_mid_wait();
    test_random(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage MIPS core, sitting in front of the decode stage. Owns the PC register, issues one outstanding request at a time on the instruction bus, and delivers instruction, PC and fetch-exception flags to decode. Accepts branch/jump redirects from decode with MIPS delay-slot semantics, load-use stalls, and exception/ERET flushes from the commit stage.

## Interface
- RESET_PC, 32'hBFC0_0000, PC value after reset
- clk  in  1  core clock, all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- ireq_valid  out  1  instruction request valid
- ireq_addr  out  32  request address (current PC)
- ireq_ready  in  1  request accepted this cycle (addr_ok)
- iresp_valid  in  1  response data valid this cycle (data_ok)
- iresp_data  in  32  fetched instruction word
- stall  in  1  decode cannot accept (load-use hazard or downstream stall)
- ifj  in  1  decode holds a taken branch/jump this cycle
- pc_decode  in  32  branch/jump target from decode
- flush  in  1  exception or ERET redirect, highest priority
- flush_pc  in  32  flush target (handler entry or EPC)
- d_valid  out  1  decode register holds a live instruction
- d_pc  out  32  PC of instruction in decode register
- d_instr  out  32  instruction word (0 when d_valid=0 or d_adel=1)
- d_adel  out  1  instruction-fetch address error for d_pc

## Operation
- States: REQ (ireq_valid=1, ireq_addr=pc), WAIT (request accepted, awaiting iresp_valid), HOLD (word captured, decode stalled).
- REQ -> WAIT on ireq_ready; WAIT -> REQ when response taken into decode register; WAIT -> HOLD when iresp_valid & stall (word kept in hold buffer); HOLD -> REQ when stall drops (buffer moves to decode register).
- Decode register loads only when stall=0; otherwise d_* hold. When stall=0 and no fetch completes, d_valid <= 0 (bubble).
- Next-PC on fetch completion: redir_pending ? redir_pc : pc+4; redir_pending cleared.
- Redirect: ifj & !stall sets redir_pending=1, redir_pc=pc_decode. The instruction currently being fetched is the delay slot and is always delivered. If a fetch completes in the same cycle as the redirect, next pc = pc_decode directly (bypass), redir_pending stays 0.
- Flush: pc <= flush_pc, d_valid <= 0, hold buffer dropped, redir_pending cleared, state -> REQ. If flushed in WAIT with request already accepted, set kill flag: state stays WAIT, next iresp_valid is discarded, then REQ. Flush overrides ifj and stall in the same cycle.
- Address check per Configuration.

## Timing
- Reset: pc=RESET_PC, state=REQ, ireq_valid=1 from first cycle after reset release, d_valid=0, d_pc=0, d_instr=0, d_adel=0, redir_pending=0, kill=0.
- Minimum latency: request accepted cycle N, iresp_valid cycle N+1 -> d_valid=1 in N+2; next request issued in N+2 (throughput 1 instr / 2 cycles with single outstanding).
- ireq_addr stable while ireq_valid=1 and ireq_ready=0, unless flush (address may change on flush only before acceptance).
- Reset asserted mid-WAIT: state cleared immediately; bus must tolerate the orphan response (kill flag not required after reset; bus is also reset).
- iresp_valid outside WAIT is ignored.

## Configuration
- FETCH_ADEL_CHECK_EN defined: in REQ, if pc[1:0]!=0, no bus request is issued; next cycle (stall permitting) decode register loads d_adel=1, d_instr=0, d_pc=pc, and fetch parks in REQ with ireq_valid=0 until flush.
- Undefined: no check; ireq_addr = {pc[31:2],2'b00}, d_adel tied 0.

## Test plan
- Reset release, ireq_ready=1, iresp 1 cycle later with 0x24080001 -> ireq_addr=0xBFC00000, then d_valid=1, d_pc=0xBFC00000, d_instr=0x24080001; next ireq_addr=0xBFC00004.
- Stall held 3 cycles while response arrives -> d_* unchanged, HOLD, no new request; stall drop -> buffered word appears in d_*, next request pc+4.
- Branch at 0xBFC00010 with ifj=1, pc_decode=0xBFC00100 -> delay slot 0xBFC00014 delivered, next ireq_addr=0xBFC00100; repeat with response completing in same cycle as ifj (bypass path).
- Flush to 0xBFC00380 while in WAIT -> d_valid=0, stale response discarded, next ireq_addr=0xBFC00380, no instruction from old PC reaches decode.
- Flush and ifj same cycle -> flush_pc wins, redir_pending=0.
- With FETCH_ADEL_CHECK_EN, flush to 0xBFC00002 -> no ireq_valid, d_adel=1, d_pc=0xBFC00002, d_instr=0; without macro, ireq_addr=0xBFC00000.
